pixel_blend: RTL and testbench
==============================

Name: pixel_blend

Overview:
- Output compositor directly downstream of the two colormem instances (playfield A and playfield B).
- Each pixel clock it takes the two ARGB4444 palette words read from colormem and combines them according to a blend mode.
- Blanks the result outside the active display and emits 4-bit R/G/B for the video output.
- Delays hsync/vsync/DE so they stay aligned with the colormem read latency plus its own pipeline.

Parameters:
- COLOR_LATENCY, 1, read latency in clk cycles from presenting a colormem rd_address to rd_data valid; range 1..2.
- SYNC_RESET, 1'b0, value the hsync_o/vsync_o delay-line stages take on reset.

Ports:
- clk  input  1  pixel clock, same clock as the colormem read port
- reset_i  input  1  synchronous, active-high reset
- colorA_i  input  16 (word_t)  playfield A palette word from colormem A; bits [15:12]=alpha, [11:8]=R, [7:4]=G, [3:0]=B
- colorB_i  input  16 (word_t)  playfield B palette word from colormem B, same format
- blend_mode_i  input  2 (blend_mode_t)  0=A_ONLY, 1=ALPHA (B over A), 2=ADD (saturating), 3=KEY (B if alphaB!=0 else A)
- pfB_en_i  input  1  playfield B enable; 0 forces A_ONLY
- vid_de_i  input  1  display enable, aligned with the cycle colormem rd_address is presented
- hsync_i  input  1  horizontal sync, already at the output polarity, same alignment as vid_de_i
- vsync_i  input  1  vertical sync, same alignment as vid_de_i
- red_o  output  4  blended red
- green_o  output  4  blended green
- blue_o  output  4  blended blue
- vid_de_o  output  1  delayed DE
- hsync_o  output  1  delayed hsync
- vsync_o  output  1  delayed vsync

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (reset_i).
- Reset values:
  - red_o, green_o, blue_o, vid_de_o = 0.
  - hsync_o, vsync_o and every sync delay-stage = SYNC_RESET.
  - All pipeline data registers = 0.
- Total latency L = COLOR_LATENCY + 2 cycles from vid_de_i/hsync_i/vsync_i to the outputs.
- Color inputs are consumed COLOR_LATENCY cycles after their matching DE sample.
- Mode handling: blend_mode_i and pfB_en_i are delayed COLOR_LATENCY cycles so each applies to the pixel whose address was presented with it. A mode change takes effect on an exact pixel boundary.
- Stage 1 (registered):
  - Effective mode = A_ONLY if !pfB_en.
  - Weight w (5 bits) = 16 if alphaB==15, else alphaB.
  - Per channel: pa = A_c*(16-w), pb = B_c*w, each 8 bits unsigned. Also register the raw channel values, the effective mode and the delayed DE.
- Stage 2 (registered outputs):
  - A_ONLY: out = A_c.
  - ALPHA: out = (pa+pb)>>4. The maximum sum is 240, so the result is at most 15 and no clamp is needed.
  - ADD: out = min(A_c+B_c, 15), computed as 5-bit then saturated.
  - KEY: out = B_c if alphaB!=0, else A_c.
  - If the delayed DE is 0, out = 0 regardless of mode.
- Alpha of A is ignored in all modes.
- Boundaries:
  - alphaB=0 in ALPHA gives exactly A; alphaB=15 gives exactly B.
  - The first DE-high cycle after blanking produces a pixel exactly L cycles later; there is no leakage of a prior pixel.
  - Reset mid-line clears the pipeline. Outputs show blank/SYNC_RESET for L cycles after release, then track the inputs.
- No handshake; the block runs every cycle.

Decomposition:
- Shared package (xosera_pkg):
  - blend_mode_t enum.
  - ARGB4444 field position constants (ALPHA_HI/LO, R_HI/LO, G_HI/LO, B_HI/LO).
- Sub-module blend_channel:
  - Per-channel two-stage arithmetic, instantiated 3x.
  - Inputs: A_c, B_c, w, keyB, mode, de.
  - Output: 4-bit channel.
- The top level holds:
  - The COLOR_LATENCY delay of mode/pfB_en.
  - The L-stage DE/hsync/vsync shift registers.
  - Weight and key generation.

Test Plan:
- ALPHA mode, A=0x0F00, B=0xF00F, de=1 -> L cycles later RGB = 0,0,F. Then B=0x800F -> RGB = 7,0,7.
- ADD mode, A=0x0A53, B=0x0898 -> RGB = F,E,B. Also A=0x0123, B=0x0111 -> RGB = 2,3,4.
- KEY mode, B=0x0FFF then B=0x1FFF with A=0x0123 -> RGB = 1,2,3 then F,F,F. Then pfB_en_i=0 with ALPHA, B=0xF00F -> RGB = 1,2,3.
- Latency/alignment: a single-cycle DE pulse with a distinct hsync pattern and COLOR_LATENCY=1 -> vid_de_o high exactly at cycle+3 with hsync_o matching. RGB is 0 on all cycles where vid_de_o is 0, even when colorA_i is nonzero.
- Mode switch per pixel: alternate blend_mode_i A_ONLY/ADD every cycle over 8 pixels with A=0x0888, B=0x0888 -> outputs alternate 888/FFF with no skew.
- Assert reset_i mid-line for 2 cycles -> outputs 0 and syncs = SYNC_RESET on the next edge. After release, the first valid pixel appears L cycles after the first DE-high input.

Source files
------------

// File: rtl/xosera_pkg.sv
// xosera_pkg
//    Shared definitions for the output compositor.
//    - word_t        : one ARGB4444 palette word as read from colormem
//    - blend_mode_t  : how playfield B is combined with playfield A
//    - field bounds  : bit positions of the alpha/R/G/B nibbles in word_t
//    - alpha_weight  : maps a 4-bit alpha onto the 0..16 blend weight

package xosera_pkg;

   typedef logic [15:0] word_t;

   typedef enum logic [1:0] {
      BLEND_A_ONLY = 2'd0,
      BLEND_ALPHA  = 2'd1,
      BLEND_ADD    = 2'd2,
      BLEND_KEY    = 2'd3
   } blend_mode_t;

   localparam int ALPHA_HI = 15;
   localparam int ALPHA_LO = 12;
   localparam int R_HI     = 11;
   localparam int R_LO     = 8;
   localparam int G_HI     = 7;
   localparam int G_LO     = 4;
   localparam int B_HI     = 3;
   localparam int B_LO     = 0;

   // Alpha 15 is treated as fully opaque (weight 16) so that an opaque
   // B pixel reproduces B exactly instead of 15/16 of it.
   function automatic logic [4:0] alpha_weight(input logic [3:0] alpha);
      return (alpha == 4'hF) ? 5'd16 : {1'b0, alpha};
   endfunction

endpackage

// File: rtl/blend_channel.sv
// blend_channel
//    Two-stage arithmetic for one colour channel of the compositor.
//    Stage 1 registers the weighted products and the raw channel values,
//    stage 2 selects the result for the pixel's mode and blanks it when
//    the pixel lies outside the active display.
// Ports:
//    clk      - pixel clock
//    reset_i  - synchronous active-high reset
//    a_i      - playfield A channel value
//    b_i      - playfield B channel value
//    w_i      - blend weight of B, 0..16
//    key_b_i  - B alpha is non-zero (B is opaque for keying)
//    mode_i   - effective blend mode for this pixel
//    de_i     - display enable aligned with a_i/b_i
//    chan_o   - registered 4-bit result

module blend_channel
   import xosera_pkg::*;
(
   input  logic        clk,
   input  logic        reset_i,
   input  logic [3:0]  a_i,
   input  logic [3:0]  b_i,
   input  logic [4:0]  w_i,
   input  logic        key_b_i,
   input  blend_mode_t mode_i,
   input  logic        de_i,
   output logic [3:0]  chan_o
);

   logic [4:0]  inv_w;
   logic [7:0]  pa_d, pa_q;
   logic [7:0]  pb_d, pb_q;
   logic [3:0]  a_d, a_q;
   logic [3:0]  b_d, b_q;
   logic        key_d, key_q;
   logic        de_d, de_q;
   blend_mode_t mode_d, mode_q;

   logic [7:0]  alpha_sum;
   logic [4:0]  add_sum;
   logic [3:0]  chan_d, chan_q;

   // Stage 1: the two weights always add up to 16, so each product is at
   // most 15*16 = 240 and fits in 8 bits.
   always_comb begin
      inv_w  = 5'd16 - w_i;
      pa_d   = {4'b0000, a_i} * {3'b000, inv_w};
      pb_d   = {4'b0000, b_i} * {3'b000, w_i};
      a_d    = a_i;
      b_d    = b_i;
      key_d  = key_b_i;
      mode_d = mode_i;
      de_d   = de_i;
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         pa_q   <= '0;
         pb_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         key_q  <= 1'b0;
         mode_q <= BLEND_A_ONLY;
         de_q   <= 1'b0;
      end else begin
         pa_q   <= pa_d;
         pb_q   <= pb_d;
         a_q    <= a_d;
         b_q    <= b_d;
         key_q  <= key_d;
         mode_q <= mode_d;
         de_q   <= de_d;
      end
   end

   // Stage 2: the weighted sum never exceeds 240, so its top nibble is
   // the blended value without any clamp. ADD is done one bit wider and
   // saturated to full intensity.
   always_comb begin
      alpha_sum = pa_q + pb_q;
      add_sum   = {1'b0, a_q} + {1'b0, b_q};
      chan_d    = a_q;
      case (mode_q)
         BLEND_A_ONLY: chan_d = a_q;
         BLEND_ALPHA:  chan_d = alpha_sum[7:4];
         BLEND_ADD:    chan_d = add_sum[4] ? 4'hF : add_sum[3:0];
         BLEND_KEY:    chan_d = key_q ? b_q : a_q;
         default:      chan_d = a_q;
      endcase
      if (!de_q) begin
         chan_d = 4'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         chan_q <= '0;
      end else begin
         chan_q <= chan_d;
      end
   end

   assign chan_o = chan_q;

endmodule

// File: rtl/pixel_blend.sv
// pixel_blend
//    Output compositor sitting after the two colormem read ports. Combines
//    the playfield A and B palette words per pixel according to the blend
//    mode, blanks outside the active display and delays the video timing
//    signals so they leave together with the matching pixel, COLOR_LATENCY+2
//    cycles after they entered.
// Ports:
//    clk           - pixel clock, shared with the colormem read ports
//    reset_i       - synchronous active-high reset
//    colorA_i      - playfield A ARGB4444 word (alpha ignored)
//    colorB_i      - playfield B ARGB4444 word
//    blend_mode_i  - blend mode, aligned with vid_de_i
//    pfB_en_i      - playfield B enable, aligned with vid_de_i
//    vid_de_i      - display enable, aligned with the colormem address
//    hsync_i       - horizontal sync, output polarity
//    vsync_i       - vertical sync, output polarity
//    red_o/green_o/blue_o - blended 4-bit colour
//    vid_de_o, hsync_o, vsync_o - timing delayed to match the colour

module pixel_blend
   import xosera_pkg::*;
#(
   parameter int   COLOR_LATENCY = 1,
   parameter logic SYNC_RESET    = 1'b0
) (
   input  logic        clk,
   input  logic        reset_i,
   input  word_t       colorA_i,
   input  word_t       colorB_i,
   input  blend_mode_t blend_mode_i,
   input  logic        pfB_en_i,
   input  logic        vid_de_i,
   input  logic        hsync_i,
   input  logic        vsync_i,
   output logic [3:0]  red_o,
   output logic [3:0]  green_o,
   output logic [3:0]  blue_o,
   output logic        vid_de_o,
   output logic        hsync_o,
   output logic        vsync_o
);

   localparam int L = COLOR_LATENCY + 2;

   logic [2:0]  ctl_d [COLOR_LATENCY];
   logic [2:0]  ctl_q [COLOR_LATENCY];
   logic [2:0]  ctl_out;
   blend_mode_t eff_mode;

   logic [L-1:0] de_pipe_d, de_pipe_q;
   logic [L-1:0] hs_pipe_d, hs_pipe_q;
   logic [L-1:0] vs_pipe_d, vs_pipe_q;

   logic [4:0]  weight_b;
   logic        key_b;
   logic [3:0]  red_w, green_w, blue_w;
   logic        unused_alpha_a;

   // The mode and B enable travel alongside the colormem read so they
   // reach the arithmetic in the same cycle as the pixel they were
   // presented with; this makes mode changes land on exact pixel edges.
   always_comb begin
      ctl_d[0] = {pfB_en_i, blend_mode_i};
      for (int i = 1; i < COLOR_LATENCY; i++) begin
         ctl_d[i] = ctl_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         for (int i = 0; i < COLOR_LATENCY; i++) begin
            ctl_q[i] <= '0;
         end
      end else begin
         ctl_q <= ctl_d;
      end
   end

   // With playfield B disabled the pixel is always plain A.
   always_comb begin
      ctl_out  = ctl_q[COLOR_LATENCY-1];
      eff_mode = ctl_out[2] ? blend_mode_t'(ctl_out[1:0]) : BLEND_A_ONLY;
   end

   // Timing shift registers. DE tapped after COLOR_LATENCY stages feeds the
   // arithmetic so blanking follows the same pixel as the colour data; the
   // last stage drives the outputs.
   always_comb begin
      de_pipe_d = {de_pipe_q[L-2:0], vid_de_i};
      hs_pipe_d = {hs_pipe_q[L-2:0], hsync_i};
      vs_pipe_d = {vs_pipe_q[L-2:0], vsync_i};
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         de_pipe_q <= '0;
         hs_pipe_q <= {L{SYNC_RESET}};
         vs_pipe_q <= {L{SYNC_RESET}};
      end else begin
         de_pipe_q <= de_pipe_d;
         hs_pipe_q <= hs_pipe_d;
         vs_pipe_q <= vs_pipe_d;
      end
   end

   // Weight and key depend only on B's alpha, so they are shared by the
   // three channels. A's alpha takes no part in compositing.
   always_comb begin
      weight_b = alpha_weight(colorB_i[ALPHA_HI:ALPHA_LO]);
      key_b    = |colorB_i[ALPHA_HI:ALPHA_LO];
   end

   assign unused_alpha_a = ^colorA_i[ALPHA_HI:ALPHA_LO];

   blend_channel u_red (
      .clk     (clk),
      .reset_i (reset_i),
      .a_i     (colorA_i[R_HI:R_LO]),
      .b_i     (colorB_i[R_HI:R_LO]),
      .w_i     (weight_b),
      .key_b_i (key_b),
      .mode_i  (eff_mode),
      .de_i    (de_pipe_q[COLOR_LATENCY-1]),
      .chan_o  (red_w)
   );

   blend_channel u_green (
      .clk     (clk),
      .reset_i (reset_i),
      .a_i     (colorA_i[G_HI:G_LO]),
      .b_i     (colorB_i[G_HI:G_LO]),
      .w_i     (weight_b),
      .key_b_i (key_b),
      .mode_i  (eff_mode),
      .de_i    (de_pipe_q[COLOR_LATENCY-1]),
      .chan_o  (green_w)
   );

   blend_channel u_blue (
      .clk     (clk),
      .reset_i (reset_i),
      .a_i     (colorA_i[B_HI:B_LO]),
      .b_i     (colorB_i[B_HI:B_LO]),
      .w_i     (weight_b),
      .key_b_i (key_b),
      .mode_i  (eff_mode),
      .de_i    (de_pipe_q[COLOR_LATENCY-1]),
      .chan_o  (blue_w)
   );

   assign red_o    = red_w;
   assign green_o  = green_w;
   assign blue_o   = blue_w;
   assign vid_de_o = de_pipe_q[L-1];
   assign hsync_o  = hs_pipe_q[L-1];
   assign vsync_o  = vs_pipe_q[L-1];

endmodule

// File: tb/tb_pixel_blend.sv
// tb_pixel_blend
//    Self-checking bench for pixel_blend. Every cycle a pixel record
//    (timing, mode, the two palette words) is applied; the palette words are
//    presented COLOR_LATENCY cycles later as colormem would. Expected outputs
//    come from a per-pixel reference computed with plain arithmetic from the
//    blend rules, looked up L cycles back in the applied history.

module tb_pixel_blend;
   import xosera_pkg::*;

   localparam int   CL   = 1;
   localparam logic SR   = 1'b1;
   localparam int   L    = CL + 2;
   localparam int   MAXC = 4096;

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic [1:0]  mode;
      logic        pfb;
      logic [15:0] a;
      logic [15:0] b;
   } pixel_t;

   logic        clk;
   logic        reset_i;
   word_t       colorA_i;
   word_t       colorB_i;
   blend_mode_t blend_mode_i;
   logic        pfB_en_i;
   logic        vid_de_i;
   logic        hsync_i;
   logic        vsync_i;
   logic [3:0]  red_o;
   logic [3:0]  green_o;
   logic [3:0]  blue_o;
   logic        vid_de_o;
   logic        hsync_o;
   logic        vsync_o;

   pixel_t hist [MAXC];
   logic   rst_hist [MAXC];
   int     cyc = 0;
   int     n_checks = 0;
   int     n_fail = 0;

   logic [11:0] exp_rgb;
   logic        exp_de;
   logic        exp_hs;
   logic        exp_vs;

   pixel_blend #(
      .COLOR_LATENCY (CL),
      .SYNC_RESET    (SR)
   ) dut (
      .clk          (clk),
      .reset_i      (reset_i),
      .colorA_i     (colorA_i),
      .colorB_i     (colorB_i),
      .blend_mode_i (blend_mode_i),
      .pfB_en_i     (pfB_en_i),
      .vid_de_i     (vid_de_i),
      .hsync_i      (hsync_i),
      .vsync_i      (vsync_i),
      .red_o        (red_o),
      .green_o      (green_o),
      .blue_o       (blue_o),
      .vid_de_o     (vid_de_o),
      .hsync_o      (hsync_o),
      .vsync_o      (vsync_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference rule for one channel of one pixel.
   function automatic logic [3:0] ref_chan(input logic [1:0] mode, input logic pfb,
                                           input logic [3:0] alpha_b,
                                           input logic [3:0] a, input logic [3:0] b);
      int ai, bi, al;
      ai = int'(a);
      bi = int'(b);
      al = int'(alpha_b);
      if (!pfb) return a;
      case (mode)
         2'd1: begin
            if (al == 15) return b;
            return 4'((ai * (16 - al) + bi * al) / 16);
         end
         2'd2: return (ai + bi > 15) ? 4'hF : 4'(ai + bi);
         2'd3: return (al != 0) ? b : a;
         default: return a;
      endcase
   endfunction

   function automatic pixel_t mk(input logic de, input logic hs, input logic vs,
                                 input logic [1:0] mode, input logic pfb,
                                 input logic [15:0] a, input logic [15:0] b);
      pixel_t p;
      p.de = de; p.hs = hs; p.vs = vs; p.mode = mode; p.pfb = pfb; p.a = a; p.b = b;
      return p;
   endfunction

   function automatic pixel_t rand_pixel();
      pixel_t p;
      p.de   = 1'($urandom_range(0, 3) != 0);
      p.hs   = 1'($urandom_range(0, 1));
      p.vs   = 1'($urandom_range(0, 1));
      p.mode = 2'($urandom_range(0, 3));
      p.pfb  = 1'($urandom_range(0, 4) != 0);
      p.a    = 16'($urandom);
      p.b    = 16'($urandom);
      case ($urandom_range(0, 3))
         0: p.b[15:12] = 4'h0;
         1: p.b[15:12] = 4'hF;
         default: ;
      endcase
      return p;
   endfunction

   // Expected outputs seen just after edge n: the pixel applied L-1 cycles
   // earlier, unless a reset edge fell anywhere in its flight.
   task automatic model_at(input int n);
      int     m;
      logic   flushed;
      pixel_t px;
      m = n - L + 1;
      flushed = (m < 0);
      if (!flushed) begin
         for (int k = m; k <= n; k++) begin
            if (rst_hist[k]) flushed = 1'b1;
         end
      end
      if (flushed) begin
         exp_rgb = 12'h000; exp_de = 1'b0; exp_hs = SR; exp_vs = SR;
      end else begin
         px = hist[m];
         exp_de = px.de; exp_hs = px.hs; exp_vs = px.vs;
         if (!px.de) exp_rgb = 12'h000;
         else exp_rgb = {ref_chan(px.mode, px.pfb, px.b[15:12], px.a[11:8], px.b[11:8]),
                         ref_chan(px.mode, px.pfb, px.b[15:12], px.a[7:4],  px.b[7:4]),
                         ref_chan(px.mode, px.pfb, px.b[15:12], px.a[3:0],  px.b[3:0])};
      end
   endtask

   // Applies one cycle of stimulus, advances past the clock edge and
   // refreshes the expected outputs.
   task automatic step(input pixel_t px, input logic rst);
      if (cyc >= MAXC) begin
         $display("[TB] FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
         $fatal(1, "[TB] history exhausted");
      end
      hist[cyc]     = px;
      rst_hist[cyc] = rst;
      reset_i       = rst;
      vid_de_i      = px.de;
      hsync_i       = px.hs;
      vsync_i       = px.vs;
      blend_mode_i  = blend_mode_t'(px.mode);
      pfB_en_i      = px.pfb;
      if (cyc >= CL) begin
         colorA_i = hist[cyc-CL].a;
         colorB_i = hist[cyc-CL].b;
      end else begin
         colorA_i = 16'h0;
         colorB_i = 16'h0;
      end
      @(posedge clk);
      #1;
      model_at(cyc);
      cyc++;
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      for (int i = 0; i < 3; i++) begin
         step(rand_pixel(), 1'b1);
         n_checks++;
         if ({red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o} !== {12'h000, 1'b0, SR, SR}) begin
            n_fail++;
            $display("[TB] FAIL reset_values got=%h exp=%h", {red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o}, {12'h000, 1'b0, SR, SR});
         end
      end
   endtask

   task automatic test_alpha();
      pixel_t      seq[$];
      logic [11:0] want[$];
      $display("[TB] test_alpha");
      seq.push_back(mk(1, 1, 0, 2'd1, 1, 16'h0F00, 16'hF00F)); want.push_back(12'h00F);
      seq.push_back(mk(1, 0, 1, 2'd1, 1, 16'h0F00, 16'h800F)); want.push_back(12'h707);
      seq.push_back(mk(1, 1, 1, 2'd1, 1, 16'h0F00, 16'h000F)); want.push_back(12'hF00);
      for (int i = 0; i < seq.size() + L; i++) begin
         step((i < seq.size()) ? seq[i] : mk(0, 0, 0, 2'd1, 1, 16'hFFFF, 16'hFFFF), 1'b0);
         n_checks++;
         if ({red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o} !== {exp_rgb, exp_de, exp_hs, exp_vs}) begin
            n_fail++;
            $display("[TB] FAIL alpha_model cyc=%0d got=%h exp=%h", cyc, {red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o}, {exp_rgb, exp_de, exp_hs, exp_vs});
         end
         if (i >= L - 1 && i - (L - 1) < want.size()) begin
            n_checks++;
            if ({red_o, green_o, blue_o} !== want[i-L+1]) begin
               n_fail++;
               $display("[TB] FAIL alpha_rgb idx=%0d got=%h exp=%h", i - L + 1, {red_o, green_o, blue_o}, want[i-L+1]);
            end
         end
      end
   endtask

   task automatic test_add();
      pixel_t      seq[$];
      logic [11:0] want[$];
      $display("[TB] test_add");
      seq.push_back(mk(1, 0, 0, 2'd2, 1, 16'h0A53, 16'h0898)); want.push_back(12'hFEB);
      seq.push_back(mk(1, 0, 0, 2'd2, 1, 16'h0123, 16'h0111)); want.push_back(12'h234);
      seq.push_back(mk(1, 0, 0, 2'd2, 1, 16'hF0F0, 16'h00FF)); want.push_back(12'h0FF);
      for (int i = 0; i < seq.size() + L; i++) begin
         step((i < seq.size()) ? seq[i] : mk(0, 1, 0, 2'd2, 1, 16'h0777, 16'h0777), 1'b0);
         n_checks++;
         if ({red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o} !== {exp_rgb, exp_de, exp_hs, exp_vs}) begin
            n_fail++;
            $display("[TB] FAIL add_model cyc=%0d got=%h exp=%h", cyc, {red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o}, {exp_rgb, exp_de, exp_hs, exp_vs});
         end
         if (i >= L - 1 && i - (L - 1) < want.size()) begin
            n_checks++;
            if ({red_o, green_o, blue_o} !== want[i-L+1]) begin
               n_fail++;
               $display("[TB] FAIL add_rgb idx=%0d got=%h exp=%h", i - L + 1, {red_o, green_o, blue_o}, want[i-L+1]);
            end
         end
      end
   endtask

   task automatic test_key();
      pixel_t      seq[$];
      logic [11:0] want[$];
      $display("[TB] test_key");
      seq.push_back(mk(1, 0, 0, 2'd3, 1, 16'h0123, 16'h0FFF)); want.push_back(12'h123);
      seq.push_back(mk(1, 0, 0, 2'd3, 1, 16'h0123, 16'h1FFF)); want.push_back(12'hFFF);
      seq.push_back(mk(1, 0, 0, 2'd1, 0, 16'h0123, 16'hF00F)); want.push_back(12'h123);
      for (int i = 0; i < seq.size() + L; i++) begin
         step((i < seq.size()) ? seq[i] : mk(0, 0, 1, 2'd3, 1, 16'h0456, 16'h1789), 1'b0);
         n_checks++;
         if ({red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o} !== {exp_rgb, exp_de, exp_hs, exp_vs}) begin
            n_fail++;
            $display("[TB] FAIL key_model cyc=%0d got=%h exp=%h", cyc, {red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o}, {exp_rgb, exp_de, exp_hs, exp_vs});
         end
         if (i >= L - 1 && i - (L - 1) < want.size()) begin
            n_checks++;
            if ({red_o, green_o, blue_o} !== want[i-L+1]) begin
               n_fail++;
               $display("[TB] FAIL key_rgb idx=%0d got=%h exp=%h", i - L + 1, {red_o, green_o, blue_o}, want[i-L+1]);
            end
         end
      end
   endtask

   task automatic test_latency();
      pixel_t seq[$];
      int     pulse_at;
      $display("[TB] test_latency");
      seq.push_back(mk(0, 1, 0, 2'd0, 0, 16'h0FFF, 16'h0000));
      seq.push_back(mk(0, 0, 0, 2'd0, 0, 16'h0ABC, 16'h0000));
      seq.push_back(mk(1, 1, 1, 2'd0, 0, 16'h0ABC, 16'h0000));
      seq.push_back(mk(0, 0, 0, 2'd0, 0, 16'h0DEF, 16'h0000));
      seq.push_back(mk(0, 1, 0, 2'd0, 0, 16'h0321, 16'h0000));
      seq.push_back(mk(0, 1, 1, 2'd0, 0, 16'h0999, 16'h0000));
      seq.push_back(mk(0, 0, 0, 2'd0, 0, 16'h0555, 16'h0000));
      pulse_at = 2;
      for (int i = 0; i < seq.size(); i++) begin
         step(seq[i], 1'b0);
         n_checks++;
         if ({red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o} !== {exp_rgb, exp_de, exp_hs, exp_vs}) begin
            n_fail++;
            $display("[TB] FAIL latency_model cyc=%0d got=%h exp=%h", cyc, {red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o}, {exp_rgb, exp_de, exp_hs, exp_vs});
         end
         if (i >= L - 1) begin
            n_checks++;
            if ({vid_de_o, hsync_o} !== {1'(i == pulse_at + L - 1), seq[i-L+1].hs}) begin
               n_fail++;
               $display("[TB] FAIL latency_align idx=%0d got=%b exp=%b", i, {vid_de_o, hsync_o}, {1'(i == pulse_at + L - 1), seq[i-L+1].hs});
            end
            n_checks++;
            if (!vid_de_o && {red_o, green_o, blue_o} !== 12'h000) begin
               n_fail++;
               $display("[TB] FAIL blank_rgb idx=%0d got=%h exp=000", i, {red_o, green_o, blue_o});
            end
         end
      end
   endtask

   task automatic test_mode_switch();
      logic [11:0] want;
      $display("[TB] test_mode_switch");
      for (int i = 0; i < 8 + L; i++) begin
         step((i < 8) ? mk(1, 0, 0, (i % 2 == 0) ? 2'd0 : 2'd2, 1, 16'h0888, 16'h0888)
                      : mk(0, 0, 0, 2'd2, 1, 16'h0888, 16'h0888), 1'b0);
         n_checks++;
         if ({red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o} !== {exp_rgb, exp_de, exp_hs, exp_vs}) begin
            n_fail++;
            $display("[TB] FAIL switch_model cyc=%0d got=%h exp=%h", cyc, {red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o}, {exp_rgb, exp_de, exp_hs, exp_vs});
         end
         if (i >= L - 1 && i - (L - 1) < 8) begin
            want = ((i - (L - 1)) % 2 == 0) ? 12'h888 : 12'hFFF;
            n_checks++;
            if ({red_o, green_o, blue_o} !== want) begin
               n_fail++;
               $display("[TB] FAIL switch_rgb idx=%0d got=%h exp=%h", i - L + 1, {red_o, green_o, blue_o}, want);
            end
         end
      end
   endtask

   task automatic test_reset_midline();
      pixel_t p;
      int     first_de;
      $display("[TB] test_reset_midline");
      first_de = 10;
      for (int i = 0; i < 16; i++) begin
         p = rand_pixel();
         p.de = (i < 8) ? 1'b1 : (i >= first_de);
         p.hs = 1'b0;
         p.vs = 1'b0;
         step(p, 1'(i == 6 || i == 7));
         n_checks++;
         if ({red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o} !== {exp_rgb, exp_de, exp_hs, exp_vs}) begin
            n_fail++;
            $display("[TB] FAIL midreset_model cyc=%0d got=%h exp=%h", cyc, {red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o}, {exp_rgb, exp_de, exp_hs, exp_vs});
         end
         if (i == 6 || i == 7) begin
            n_checks++;
            if ({red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o} !== {12'h000, 1'b0, SR, SR}) begin
               n_fail++;
               $display("[TB] FAIL midreset_clear idx=%0d got=%h exp=%h", i, {red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o}, {12'h000, 1'b0, SR, SR});
            end
         end
         if (i >= 6 && i <= first_de + L - 1) begin
            n_checks++;
            if (vid_de_o !== 1'(i == first_de + L - 1)) begin
               n_fail++;
               $display("[TB] FAIL midreset_first_de idx=%0d got=%b exp=%b", i, vid_de_o, 1'(i == first_de + L - 1));
            end
         end
      end
   endtask

   task automatic test_random();
      $display("[TB] test_random");
      for (int i = 0; i < 400; i++) begin
         step(rand_pixel(), 1'($urandom_range(0, 99) == 0));
         n_checks++;
         if ({red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o} !== {exp_rgb, exp_de, exp_hs, exp_vs}) begin
            n_fail++;
            $display("[TB] FAIL random_model cyc=%0d got=%h exp=%h", cyc, {red_o, green_o, blue_o, vid_de_o, hsync_o, vsync_o}, {exp_rgb, exp_de, exp_hs, exp_vs});
         end
      end
   endtask

   initial begin
      reset_i      = 1'b1;
      colorA_i     = 16'h0;
      colorB_i     = 16'h0;
      blend_mode_i = BLEND_A_ONLY;
      pfB_en_i     = 1'b0;
      vid_de_i     = 1'b0;
      hsync_i      = 1'b0;
      vsync_i      = 1'b0;
      test_reset();
      test_alpha();
      test_add();
      test_key();
      test_latency();
      test_mode_switch();
      test_reset_midline();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
